// File: rtl/fn1_mul_arb_pkg.sv
// Shared types for the multiplier-sharing arbiter: operand width, tag sizing
// and the {valid, tag} entry that shadows each multiplier pipeline stage.
package fn1_mul_arb_pkg;

  localparam int DW    = 16;
  localparam int N_MAX = 8;

  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Tags are sized for the largest supported requester count.
  localparam int TAG_W = tag_w(N_MAX);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic v;
    tag_t tag;
  } stage_t;

endpackage

// File: rtl/fn1_mul_share_arb_if.sv
// Requester handshake and multiplier-core bus of the shared multiplier arbiter.
interface fn1_mul_share_arb_if #(
  parameter int N  = 4,
  parameter int DW = fn1_mul_arb_pkg::DW
);
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][DW-1:0] req_a;
  logic [N-1:0][DW-1:0] req_b;
  logic [N-1:0]         rsp_valid;
  logic [N-1:0]         rsp_ready;
  logic [DW-1:0]        rsp_data;
  logic                 mul_ce;
  logic [DW-1:0]        mul_din0;
  logic [DW-1:0]        mul_din1;
  logic [DW-1:0]        mul_dout;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_dout,
    output req_ready, rsp_valid, rsp_data, mul_ce, mul_din0, mul_din1, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_dout,
    input  req_ready, rsp_valid, rsp_data, mul_ce, mul_din0, mul_din1, busy
  );
endinterface

// File: rtl/fn1_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, else
// first requester from index 0 (wrap-around).
module fn1_rr_pick
  import fn1_mul_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  tag_t         ptr,
  output tag_t         gnt,
  output logic         gnt_vld
);

  tag_t lo, hi;
  logic lo_v, hi_v;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    lo   = '0;
    hi   = '0;
    lo_v = 1'b0;
    hi_v = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo   = tag_t'(i);
        lo_v = 1'b1;
        if (i >= int'(ptr)) begin
          hi   = tag_t'(i);
          hi_v = 1'b1;
        end
      end
    end
  end

  assign gnt     = hi_v ? hi : lo;
  assign gnt_vld = lo_v;

endmodule

// File: rtl/fn1_mul_share_arb.sv
// Shares one ce-gated pipelined multiplier among N requesters; a tag pipeline
// moving in lockstep with the core routes each product back to its owner.
module fn1_mul_share_arb #(
  parameter int N       = 4,
  parameter int MUL_LAT = 3,
  parameter int DW      = 16
) (
  input  logic               clk,
  input  logic               reset,
  fn1_mul_share_arb_if.slave bus
);
  import fn1_mul_arb_pkg::*;

  stage_t        pipe_q [MUL_LAT:1];
  stage_t        head;
  tag_t          ptr_q, last_q, gnt, sel;
  logic          gnt_vld, ce, busy;
  logic [N-1:0]  rsp_oh, req_elig;
  logic [DW-1:0] din0, din1;

  function automatic logic [N-1:0] onehot(input tag_t t);
    logic [N-1:0] oh;
    oh = '0;
    for (int i = 0; i < N; i++)
      if (tag_t'(i) == t) oh[i] = 1'b1;
    return oh;
  endfunction

  // Only an unaccepted head result can freeze the core and the tag pipeline.
  assign head     = pipe_q[MUL_LAT];
  assign rsp_oh   = head.v ? onehot(head.tag) : '0;
  assign ce       = ~|(rsp_oh & ~bus.rsp_ready);
  assign req_elig = bus.req_valid & {N{ce & ~reset}};

  fn1_rr_pick #(.N(N)) u_pick (
    .req     (req_elig),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  // Idle cycles keep presenting the last winner so the core never sees X.
  assign sel = gnt_vld ? gnt : last_q;

  always_comb begin
    din0 = bus.req_a[0];
    din1 = bus.req_b[0];
    for (int i = 0; i < N; i++) begin
      if (tag_t'(i) == sel) begin
        din0 = bus.req_a[i];
        din1 = bus.req_b[i];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 1; s <= MUL_LAT; s++) busy |= pipe_q[s].v;
  end

  assign bus.req_ready = gnt_vld ? onehot(gnt) : '0;
  assign bus.rsp_valid = rsp_oh;
  assign bus.rsp_data  = bus.mul_dout;
  assign bus.mul_ce    = ce;
  assign bus.mul_din0  = din0;
  assign bus.mul_din1  = din1;
  assign bus.busy      = busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 1; s <= MUL_LAT; s++) pipe_q[s] <= '0;
      ptr_q  <= '0;
      last_q <= '0;
    end else if (ce) begin
      pipe_q[1] <= '{v: gnt_vld, tag: gnt};
      for (int s = 2; s <= MUL_LAT; s++) pipe_q[s] <= pipe_q[s-1];
      if (gnt_vld) begin
        ptr_q  <= (gnt == tag_t'(N - 1)) ? '0 : tag_t'(gnt + 1'b1);
        last_q <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_fn1_mul_share_arb.sv
// Directed bench for fn1_mul_share_arb with a behavioural 3-stage ce-gated
// multiplier core and a scoreboard of hand-computed products.
module tb_fn1_mul_share_arb;
  localparam int N  = 4;
  localparam int L  = 3;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fn1_mul_share_arb_if #(.N(N), .DW(DW)) bus ();

  fn1_mul_share_arb #(.N(N), .MUL_LAT(L), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Core: input reg, multiply reg, output reg, all ce-gated, no reset.
  logic [DW-1:0]          c_a, c_b, c_p, c_out;
  logic signed [2*DW-1:0] c_full;
  assign c_full = $signed(c_a) * $signed(c_b);
  always @(posedge clk)
    if (bus.mul_ce) begin
      c_a   <= bus.mul_din0;
      c_b   <= bus.mul_din1;
      c_p   <= c_full[DW-1:0];
      c_out <= c_p;
    end
  assign bus.mul_dout = c_out;

  typedef struct {
    int          owner;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] cur_exp [N];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue tracker and response monitor, both sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) sb.push_back('{i, cur_exp[i]});
      if (|(bus.rsp_valid & bus.rsp_ready)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b data=%h, expected no response", bus.rsp_valid, bus.rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", 32'(bus.rsp_valid), 32'(1 << e.owner));
          chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] i, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e);
    bus.req_a[i] = a;
    bus.req_b[i] = b;
    cur_exp[i]   = e;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (bus.busy && n < max) begin
      step();
      n++;
    end
    chk(name, 32'(bus.busy), 0);
    chk({name, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < N; i++) cur_exp[i] = '0;

    // Reset state, with a request pending that must not be accepted.
    set_op(2'd0, 16'h0003, 16'hFFFC, 16'hFFF4);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_mul_ce", 32'(bus.mul_ce), 1);
    chk("reset_req_ready", 32'(bus.req_ready), 0);
    bus.req_valid = '0;
    reset = 1'b0;

    // Single op: 3 * -4, result two edges after the accept edge.
    step();
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("single_ready", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_busy", 32'(bus.busy), 1);
    chk("single_early0", 32'(bus.rsp_valid), 0);
    step();
    @(negedge clk);
    chk("single_early1", 32'(bus.rsp_valid), 0);
    step();
    @(negedge clk);
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
    chk("single_busy_out", 32'(bus.busy), 1);
    step();
    chk("single_idle", 32'(bus.busy), 0);

    // Round robin from pointer 0, including truncation cases.
    do_reset();
    step();
    set_op(2'd0, 16'h0005, 16'h0007, 16'h0023);
    set_op(2'd1, 16'hFFFE, 16'h0009, 16'hFFEE);
    set_op(2'd2, 16'h012C, 16'h012C, 16'h5F90);
    set_op(2'd3, 16'h8000, 16'hFFFF, 16'h8000);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      step();
    end
    bus.req_valid = '0;
    wait_idle("rr_drain", 20);

    // Backpressure: pointer now 1, owners 1,2,3 in flight, head blocked.
    bus.rsp_ready = '0;
    set_op(2'd1, 16'h0064, 16'hFF9C, 16'hD8F0);
    set_op(2'd2, 16'hFFF9, 16'hFFF8, 16'h0038);
    set_op(2'd3, 16'h04D2, 16'h0002, 16'h09A4);
    bus.req_valid = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_grant", 32'(bus.req_ready), 32'(2 << k));
      step();
    end
    set_op(2'd2, 16'hFFFF, 16'hFFFF, 16'h0001);
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_mul_ce", 32'(bus.mul_ce), 0);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
      chk("bp_rsp_data", 32'(bus.rsp_data), 32'hD8F0);
      step();
    end
    // Drain and accept in the same cycle.
    bus.rsp_ready = '1;
    @(negedge clk);
    chk("da_req_ready", 32'(bus.req_ready), 32'b0100);
    chk("da_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
    chk("da_mul_ce", 32'(bus.mul_ce), 1);
    step();
    bus.req_valid = '0;
    wait_idle("bp_drain", 20);

    // Reset mid-flight: pointer now 3, owners 3 then 1 in flight.
    bus.rsp_ready = '0;
    set_op(2'd1, 16'h0002, 16'h0002, 16'h0004);
    set_op(2'd3, 16'hFFFD, 16'h0005, 16'hFFF1);
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("rf_grant0", 32'(bus.req_ready), 32'b1000);
    step();
    @(negedge clk);
    chk("rf_grant1", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = '0;
    step();
    @(negedge clk);
    chk("rf_pre_valid", 32'(bus.rsp_valid), 32'b1000);
    chk("rf_pre_busy", 32'(bus.busy), 1);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("rf_rsp_valid_drop", 32'(bus.rsp_valid), 0);
    chk("rf_busy_drop", 32'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rf_no_stale", 32'(bus.rsp_valid), 0);
      step();
    end
    set_op(2'd0, 16'h0010, 16'h0010, 16'h0100);
    set_op(2'd1, 16'h0002, 16'h0003, 16'h0006);
    set_op(2'd2, 16'h0004, 16'h0005, 16'h0014);
    set_op(2'd3, 16'h0006, 16'h0007, 16'h002A);
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("rf_first_grant", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = '0;
    wait_idle("rf_drain", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
